// File: rtl/pkt_tx_port.sv
// Egress port transmitter: store-and-forward FIFO feeding a 32-bit sop/eop packet bus.
// Oversized fabric packets are truncated to DEPTH words and the remainder is dropped.
module pkt_tx_port #(
  parameter int DEPTH = 16,
  parameter int IPG   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] port,
  output logic        sop,
  output logic        eop,
  output logic [15:0] pkt_cnt,
  output logic        oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALMOST_LVL = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [7:0]  GAP_LOAD   = 8'(IPG - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fill, pkts_stored;
  logic        full, drop, ready_en;
  logic        wr_en, wr_last, ovs_hit, rd_en, rd_first_nxt;
  logic [32:0] head, rd_word;
  logic        rd_vld, rd_first;
  logic [7:0]  gap_cnt, gap_nxt;
  tx_state_t   state, state_nxt;

  assign fill     = wr_ptr - rd_ptr;
  assign full     = (fill == FULL_LVL);
  assign in_ready = ready_en & (drop | ~full);
  assign wr_en    = in_valid & in_ready & ~drop;
  // The word that would occupy the last free slot of a packet-less FIFO closes the packet.
  assign ovs_hit  = wr_en & (fill == ALMOST_LVL) & (pkts_stored == '0) & ~in_last;
  assign wr_last  = in_last | ovs_hit;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkts_stored <= '0;
      drop        <= 1'b0;
      ready_en    <= 1'b0;
      oversize    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      oversize <= ovs_hit;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (ovs_hit)
        drop <= 1'b1;
      else if (drop && in_valid && in_last)
        drop <= 1'b0;
      case ({wr_en & wr_last, rd_en & head[32]})
        2'b10:   pkts_stored <= pkts_stored + PTR_ONE;
        2'b01:   pkts_stored <= pkts_stored - PTR_ONE;
        default: pkts_stored <= pkts_stored;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    gap_nxt      = gap_cnt;
    rd_en        = 1'b0;
    rd_first_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pkts_stored != '0) begin
          rd_en        = 1'b1;
          rd_first_nxt = 1'b1;
          state_nxt    = head[32] ? GAP : SEND;
          gap_nxt      = GAP_LOAD;
        end
      end
      SEND: begin
        rd_en = 1'b1;
        if (head[32]) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Popped word goes through one staging register before the registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gap_cnt  <= 8'd0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      rd_word  <= '0;
      port     <= '0;
      sop      <= 1'b0;
      eop      <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= gap_nxt;
      rd_vld   <= rd_en;
      rd_first <= rd_first_nxt;
      rd_word  <= head;
      port     <= rd_vld ? rd_word[31:0] : 32'd0;
      sop      <= rd_vld & rd_first;
      eop      <= rd_vld & rd_word[32];
      if (rd_vld && rd_word[32]) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_tx_port.sv
// Self-checking bench for pkt_tx_port: table of packets plus hand-written latency,
// full-FIFO and mid-packet reset sequences, with a scoreboard on the output bus.
module tb_pkt_tx_port;

  localparam int DEPTH = 16;
  localparam int IPG   = 3;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] port;
  logic        sop;
  logic        eop;
  logic [15:0] pkt_cnt;
  logic        oversize;

  pkt_tx_port #(.DEPTH(DEPTH), .IPG(IPG)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .port(port), .sop(sop),
    .eop(eop), .pkt_cnt(pkt_cnt), .oversize(oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
  } exp_word_t;

  typedef struct {
    int          len;
    logic [31:0] base;
    int          exp_words;
    bit          drain_first;
    bit          check_gap;
    int          exp_ovs;
  } pkt_vec_t;

  exp_word_t   exp_q[$];
  exp_word_t   mon_e;
  pkt_vec_t    vecs[6];
  int          tests = 0;
  int          fails = 0;
  int          exp_cnt = 0;
  int          words_seen = 0;
  int          ovs_seen = 0;
  int          ovs_exp = 0;
  int          idle_run = 0;
  int          gap_val = -1;
  bit          gap_hit = 0;
  logic        in_pkt = 1'b0;
  logic [31:0] gap_probe = 32'hFFFF_FFFF;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Output monitor: every bus word is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pkt   = 1'b0;
        idle_run = 0;
      end else begin
        if (oversize) ovs_seen++;
        if (sop || in_pkt) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected word: got port=0x%0h sop=%0b eop=%0b, expected no word", port, sop, eop);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("port data", port, mon_e.data);
            checkOutput("sop flag", {31'd0, sop}, {31'd0, mon_e.first});
            checkOutput("eop flag", {31'd0, eop}, {31'd0, mon_e.last});
          end
          if (sop && port == gap_probe) begin
            gap_val = idle_run;
            gap_hit = 1'b1;
          end
          in_pkt = !eop;
          if (eop) begin
            exp_cnt++;
            idle_run = 0;
            checkOutput("pkt_cnt at eop", {16'd0, pkt_cnt}, exp_cnt & 32'hFFFF);
          end
        end else begin
          idle_run++;
          checkOutput("idle port", port, 32'd0);
          checkOutput("idle eop", {31'd0, eop}, 32'd0);
        end
      end
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic l);
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL in_ready timeout: got in_ready=0 for %0d cycles, expected 1", guard);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input int len, input logic [31:0] base, input int exp_words);
    exp_word_t e;
    for (int i = 0; i < exp_words; i++) begin
      e.data  = base + 32'(i);
      e.first = (i == 0);
      e.last  = (i == exp_words - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      if (i >= DEPTH) checkOutput("in_ready in drop", {31'd0, in_ready}, 32'd1);
      drive_word(base + 32'(i), i == len - 1);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || in_pkt) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || in_pkt) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain timeout: got %0d words pending, expected 0", exp_q.size());
    end
    repeat (IPG + 4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    int guard;
    rst_n    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2 rst_n = 1'b0;

    vecs[0] = '{len: 1,  base: 32'h55,  exp_words: 1,  drain_first: 1'b0, check_gap: 1'b0, exp_ovs: 0};
    vecs[1] = '{len: 3,  base: 32'h100, exp_words: 3,  drain_first: 1'b0, check_gap: 1'b0, exp_ovs: 0};
    vecs[2] = '{len: 3,  base: 32'h200, exp_words: 3,  drain_first: 1'b0, check_gap: 1'b1, exp_ovs: 0};
    vecs[3] = '{len: 20, base: 32'h300, exp_words: 16, drain_first: 1'b1, check_gap: 1'b0, exp_ovs: 1};
    vecs[4] = '{len: 2,  base: 32'h400, exp_words: 2,  drain_first: 1'b0, check_gap: 1'b0, exp_ovs: 0};
    vecs[5] = '{len: 5,  base: 32'h500, exp_words: 5,  drain_first: 1'b0, check_gap: 1'b0, exp_ovs: 0};

    repeat (2) @(negedge clk);
    checkOutput("reset port", port, 32'd0);
    checkOutput("reset sop", {31'd0, sop}, 32'd0);
    checkOutput("reset eop", {31'd0, eop}, 32'd0);
    checkOutput("reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    checkOutput("reset oversize", {31'd0, oversize}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // First word must appear exactly two edges after the last word is accepted.
    applyStimulus(4, 32'hA0, 4);
    @(negedge clk);
    checkOutput("latency edge1 sop", {31'd0, sop}, 32'd0);
    @(negedge clk);
    checkOutput("latency edge2 sop", {31'd0, sop}, 32'd1);
    checkOutput("latency edge2 port", port, 32'hA0);
    wait_drain();
    checkOutput("pkt_cnt after 4-word", {16'd0, pkt_cnt}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].drain_first) wait_drain();
      if (vecs[v].check_gap) gap_probe = vecs[v].base;
      ovs_exp += vecs[v].exp_ovs;
      applyStimulus(vecs[v].len, vecs[v].base, vecs[v].exp_words);
    end
    wait_drain();
    checkOutput("gap probe hit", {31'd0, gap_hit}, 32'd1);
    checkOutput("inter-packet gap", gap_val, IPG);
    checkOutput("pkt_cnt after table", {16'd0, pkt_cnt}, exp_cnt & 32'hFFFF);

    // Fill the FIFO completely, then write while the packet drains.
    applyStimulus(16, 32'h600, 16);
    checkOutput("in_ready when full", {31'd0, in_ready}, 32'd0);
    applyStimulus(3, 32'h700, 3);
    wait_drain();
    checkOutput("oversize pulses", ovs_seen, ovs_exp);
    checkOutput("pkt_cnt after full", {16'd0, pkt_cnt}, exp_cnt & 32'hFFFF);

    // Reset in the middle of a transmitting packet.
    target = words_seen + 2;
    applyStimulus(4, 32'hB0, 4);
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (words_seen < target && guard < 200);
    checkOutput("words before reset", words_seen, target);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    checkOutput("mid reset port", port, 32'd0);
    checkOutput("mid reset sop", {31'd0, sop}, 32'd0);
    checkOutput("mid reset eop", {31'd0, eop}, 32'd0);
    checkOutput("mid reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    checkOutput("mid reset in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("post reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    applyStimulus(2, 32'hC0, 2);
    wait_drain();
    checkOutput("pkt_cnt after reset pkt", {16'd0, pkt_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
